serial_hex_demux: RTL

- Receiving end of the team's time-multiplexed hex-digit link.
- A single 1-bit serial line carries NUM_CH hex digits per frame. Each frame is LSB-first, channel 0 first.
- The block demultiplexes the frame into NUM_CH parallel CH_W-bit channel registers that feed the seven-segment decoders.
- Channel registers are double-buffered: displays never see a partially received frame.

---
 rtl/serial_hex_demux_if.sv | 33 +++
 rtl/serial_hex_demux.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_hex_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_hex_demux_if
// Description : Serial hex-digit link bundle: bit strobe, data and sync in;
//               held channel data, frame pulses and receive status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_hex_demux_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 4
);
  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     en;
  logic                     din;
  logic                     sync;
  logic [NUM_CH*CH_W-1:0]   ch_data;
  logic                     frame_valid;
  logic                     frame_err;
  logic                     busy;
  logic [SLOT_W-1:0]        slot;

  modport master (
    output en, din, sync,
    input  ch_data, frame_valid, frame_err, busy, slot
  );

  modport slave (
    input  en, din, sync,
    output ch_data, frame_valid, frame_err, busy, slot
  );
endinterface
`default_nettype wire

// File: rtl/serial_hex_demux.sv
`default_nettype none
// ============================================================================
// Module      : serial_hex_demux
// Description : Demultiplexes an LSB-first serial frame of NUM_CH hex digits
//               into double-buffered parallel channel registers.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_hex_demux #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  serial_hex_demux_if.slave    bus
);
  localparam int FRAME_BITS = NUM_CH * CH_W;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int SLOT_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_next;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [FRAME_BITS-1:0]   w_shift_next;
  logic [FRAME_BITS-1:0]   r_ch_data;
  logic [FRAME_BITS-1:0]   w_ch_next;
  logic                    r_valid;
  logic                    w_valid_next;
  logic                    r_err;
  logic                    w_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_shift   <= '0;
      r_ch_data <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_shift   <= w_shift_next;
      r_ch_data <= w_ch_next;
      r_valid   <= w_valid_next;
      r_err     <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_shift_next = r_shift;
    w_ch_next    = r_ch_data;
    w_valid_next = 1'b0;
    w_err_next   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.en && bus.sync) begin
          w_shift_next[0] = bus.din;
          // A one-bit frame is complete on the sync bit itself.
          if (C_LAST == '0) begin
            w_ch_next    = w_shift_next;
            w_valid_next = 1'b1;
            w_count_next = '0;
          end else begin
            w_count_next = C_ONE;
            w_state_next = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (bus.en) begin
          if (bus.sync) begin
            // Early sync restarts the frame; the displayed word is untouched.
            w_shift_next[0] = bus.din;
            w_count_next    = C_ONE;
            w_err_next      = 1'b1;
          end else begin
            w_shift_next[r_count] = bus.din;
            if (r_count == C_LAST) begin
              w_ch_next    = w_shift_next;
              w_valid_next = 1'b1;
              w_count_next = '0;
              w_state_next = ST_IDLE;
            end else begin
              w_count_next = r_count + C_ONE;
            end
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.ch_data     = r_ch_data;
  assign bus.frame_valid = r_valid;
  assign bus.frame_err   = r_err;
  assign bus.busy        = (r_state == ST_RECV);
  assign bus.slot        = (r_state == ST_RECV) ? SLOT_W'(32'(r_count) / CH_W) : '0;
endmodule
`default_nettype wire
